// File: rtl/uart_program_loader_if.sv
// Program-memory write port driven by the UART boot loader.
// The loader drives it through the master modport; program memory consumes the slave side.
interface uart_program_loader_if;
   logic        write_enable;
   logic [31:0] address;
   logic [31:0] write_data;

   modport master (output write_enable, output address, output write_data);
   modport slave  (input  write_enable, input  address, input  write_data);
endinterface

// File: rtl/uart_program_loader.sv
// UART (8N1) boot loader: receives a length-prefixed image, writes 32-bit words to program memory
// and holds the core in reset until done. Define LOADER_CHECKSUM_EN for a trailing XOR check byte.
module uart_program_loader #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int MAX_WORDS   = 1024
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   io_rx,
   uart_program_loader_if.master  mem,
   output logic                   cpu_reset_n,
   output logic                   load_done,
   output logic                   load_error
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   typedef enum logic [2:0] {
      LD_LEN_LO, LD_LEN_HI, LD_WORD, LD_WRITE,
`ifdef LOADER_CHECKSUM_EN
      LD_CHECK,
`endif
      LD_DONE, LD_ERROR
   } ld_state_t;

   logic              rx_meta, rx_sync;
   rx_state_t         rx_state, rx_next;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        rx_shift;
   logic              baud_tick, half_tick, byte_valid, frame_err;

   ld_state_t         ld_state, ld_next;
   logic [7:0]        len_lo;
   logic [15:0]       len_n, len_words, word_idx;
   logic [1:0]        byte_cnt;
   logic [31:0]       word_buf, addr_q, data_q;
   logic              we_q, done_q, err_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        chk;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= io_rx;
         rx_sync <= rx_meta;
      end
   end

   assign baud_tick = (baud_cnt == BAUD_LAST);
   assign half_tick = (baud_cnt == HALF_LAST);

   // NOTE: every signal written here is defaulted first, so no path can infer a latch.
   always_comb begin
      rx_next    = rx_state;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (rx_state)
         RX_IDLE:  if (!rx_sync) rx_next = RX_START;
         RX_START: if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (baud_tick && bit_cnt == 3'd7) rx_next = RX_STOP;
         RX_STOP: begin
            if (baud_tick) begin
               rx_next    = RX_IDLE;
               byte_valid = rx_sync;
               frame_err  = !rx_sync;
            end
         end
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state <= RX_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         rx_shift <= '0;
      end else begin
         rx_state <= rx_next;
         // Restart the baud counter on every state change so each phase is timed from its own entry
         if (rx_state == RX_IDLE || rx_next != rx_state || baud_tick) baud_cnt <= '0;
         else                                                          baud_cnt <= baud_cnt + 1'b1;
         if (rx_state == RX_START) bit_cnt <= '0;
         if (rx_state == RX_DATA && baud_tick) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
         end
      end
   end

   assign len_n = {rx_shift, len_lo};

   always_comb begin
      ld_next = ld_state;
      case (ld_state)
         LD_LEN_LO: if (byte_valid) ld_next = LD_LEN_HI;
         LD_LEN_HI: begin
            if (byte_valid) begin
               if (len_n == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                  ld_next = LD_CHECK;
`else
                  ld_next = LD_DONE;
`endif
               else if ({16'd0, len_n} > 32'(MAX_WORDS)) ld_next = LD_ERROR;
               else                                       ld_next = LD_WORD;
            end
         end
         LD_WORD:   if (byte_valid && byte_cnt == 2'd3) ld_next = LD_WRITE;
         LD_WRITE: begin
            if (word_idx + 16'd1 == len_words)
`ifdef LOADER_CHECKSUM_EN
               ld_next = LD_CHECK;
`else
               ld_next = LD_DONE;
`endif
            else
               ld_next = LD_WORD;
         end
`ifdef LOADER_CHECKSUM_EN
         LD_CHECK:  if (byte_valid) ld_next = (rx_shift == chk) ? LD_DONE : LD_ERROR;
`endif
         LD_DONE:   ld_next = LD_DONE;
         default:   ld_next = LD_ERROR;
      endcase
      // A completed load ignores the line entirely, including garbage framing
      if (frame_err && ld_state != LD_DONE) ld_next = LD_ERROR;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ld_state  <= LD_LEN_LO;
         len_lo    <= '0;
         len_words <= '0;
         word_idx  <= '0;
         byte_cnt  <= '0;
         word_buf  <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         we_q      <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         chk       <= '0;
`endif
      end else begin
         ld_state <= ld_next;
         if (ld_state == LD_LEN_LO && byte_valid) len_lo    <= rx_shift;
         if (ld_state == LD_LEN_HI && byte_valid) len_words <= len_n;
         if (ld_state == LD_WORD && byte_valid) begin
            word_buf <= {rx_shift, word_buf[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            chk      <= chk ^ rx_shift;
`endif
         end
         // Address and data are latched as the word completes and then held until the next one
         if (ld_state == LD_WORD && ld_next == LD_WRITE) begin
            addr_q <= {14'd0, word_idx, 2'b00};
            data_q <= {rx_shift, word_buf[31:8]};
         end
         if (ld_state == LD_WRITE) word_idx <= word_idx + 16'd1;
         we_q   <= (ld_next == LD_WRITE);
         done_q <= (ld_next == LD_DONE);
         err_q  <= (ld_next == LD_ERROR);
      end
   end

   assign mem.write_enable = we_q;
   assign mem.address      = addr_q;
   assign mem.write_data   = data_q;
   assign cpu_reset_n      = done_q;
   assign load_done        = done_q;
   assign load_error       = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: table of whole images plus hand-written reset/glitch cases.
// Build with LOADER_CHECKSUM_EN defined to exercise the trailing checksum byte.
module tb_uart_program_loader;
   localparam int CPB = 10;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic io_rx   = 1'b1;
   logic cpu_reset_n, load_done, load_error;

   uart_program_loader_if bus ();

   uart_program_loader #(
      .CLK_FREQ_HZ (1_000_000),
      .BAUD_RATE   (100_000),
      .MAX_WORDS   (1024)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .io_rx       (io_rx),
      .mem         (bus),
      .cpu_reset_n (cpu_reset_n),
      .load_done   (load_done),
      .load_error  (load_error)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          long_strobes = 0;
   logic        we_prev = 1'b0;

   always @(negedge clk) begin
      if (bus.write_enable === 1'b1) begin
         wr_addr.push_back(bus.address);
         wr_data.push_back(bus.write_data);
         if (we_prev) long_strobes++;
      end
      we_prev = (bus.write_enable === 1'b1);
   end

   typedef struct {
      string       name;
      logic [95:0] img;       // first byte in bits 95:88
      int          n;
      int          bad_stop;  // index of byte sent with a low stop bit, -1 for none
      logic        done;
      logic        err;
      int          nw;
      logic [31:0] d0;
      logic [31:0] d1;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      io_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         io_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      io_rx = stop;
      repeat (CPB) @(negedge clk);
      io_rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_img(input logic [95:0] img, input int n, input int bad_stop);
      for (int i = 0; i < n; i++) send_byte(img[95-8*i -: 8], i != bad_stop);
   endtask

   task automatic do_reset();
      io_rx = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      wr_addr.delete();
      wr_data.delete();
      long_strobes = 0;
   endtask

   task automatic check_writes(input string name, input int nw, input logic [31:0] d0,
                               input logic [31:0] d1);
      check({name, "/n_writes"}, 32'(wr_addr.size()), 32'(nw));
      check({name, "/strobe_width"}, 32'(long_strobes), 32'd0);
      for (int k = 0; k < nw && k < wr_addr.size(); k++) begin
         check($sformatf("%s/addr%0d", name, k), wr_addr[k], 32'(k * 4));
         check($sformatf("%s/data%0d", name, k), wr_data[k], (k == 0) ? d0 : d1);
      end
   endtask

   initial begin
`ifdef LOADER_CHECKSUM_EN
      vecs.push_back('{"two_words", 96'h02_00_13_00_00_00_B3_00_50_00_F0_00, 11, -1, 1'b1, 1'b0, 2, 32'h00000013, 32'h005000B3});
      vecs.push_back('{"chk_ok",    96'h01_00_11_22_33_44_44_00_00_00_00_00, 7, -1, 1'b1, 1'b0, 1, 32'h44332211, 32'h0});
      vecs.push_back('{"chk_bad",   96'h01_00_11_22_33_44_45_00_00_00_00_00, 7, -1, 1'b0, 1'b1, 1, 32'h44332211, 32'h0});
      vecs.push_back('{"empty",     96'h00_00_00_00_00_00_00_00_00_00_00_00, 3, -1, 1'b1, 1'b0, 0, 32'h0, 32'h0});
      vecs.push_back('{"empty_nochk", 96'h00_00_00_00_00_00_00_00_00_00_00_00, 2, -1, 1'b0, 1'b0, 0, 32'h0, 32'h0});
      vecs.push_back('{"after_done", 96'h01_00_AA_BB_CC_DD_00_11_22_33_44_00, 11, -1, 1'b1, 1'b0, 1, 32'hDDCCBBAA, 32'h0});
`else
      vecs.push_back('{"two_words", 96'h02_00_13_00_00_00_B3_00_50_00_00_00, 10, -1, 1'b1, 1'b0, 2, 32'h00000013, 32'h005000B3});
      vecs.push_back('{"empty",     96'h00_00_00_00_00_00_00_00_00_00_00_00, 2, -1, 1'b1, 1'b0, 0, 32'h0, 32'h0});
      vecs.push_back('{"after_done", 96'h01_00_AA_BB_CC_DD_11_22_33_44_00_00, 10, -1, 1'b1, 1'b0, 1, 32'hDDCCBBAA, 32'h0});
`endif
      vecs.push_back('{"len_stop_low", 96'h01_00_00_00_00_00_00_00_00_00_00_00, 2, 1, 1'b0, 1'b1, 0, 32'h0, 32'h0});
      vecs.push_back('{"too_long",     96'h01_08_00_00_00_00_00_00_00_00_00_00, 2, -1, 1'b0, 1'b1, 0, 32'h0, 32'h0});
      vecs.push_back('{"max_plus_1",   96'h01_04_00_00_00_00_00_00_00_00_00_00, 2, -1, 1'b0, 1'b1, 0, 32'h0, 32'h0});
      vecs.push_back('{"payload_frame", 96'h01_00_11_22_00_00_00_00_00_00_00_00, 4, 3, 1'b0, 1'b1, 0, 32'h0, 32'h0});

      // Reset values and an idle line
      do_reset();
      check("reset/outputs", {28'd0, bus.write_enable, cpu_reset_n, load_done, load_error}, 32'd0);
      check("reset/address", bus.address, 32'd0);
      check("reset/data", bus.write_data, 32'd0);
      repeat (1000) @(negedge clk);
      check("idle/n_writes", 32'(wr_addr.size()), 32'd0);
      check("idle/cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);

      foreach (vecs[v]) begin
         do_reset();
         send_img(vecs[v].img, vecs[v].n, vecs[v].bad_stop);
         repeat (30) @(negedge clk);
         check({vecs[v].name, "/load_done"}, {31'd0, load_done}, {31'd0, vecs[v].done});
         check({vecs[v].name, "/load_error"}, {31'd0, load_error}, {31'd0, vecs[v].err});
         check({vecs[v].name, "/cpu_reset_n"}, {31'd0, cpu_reset_n}, {31'd0, vecs[v].done});
         check_writes(vecs[v].name, vecs[v].nw, vecs[v].d0, vecs[v].d1);
         if (vecs[v].nw > 0) begin
            check({vecs[v].name, "/addr_hold"}, bus.address, 32'((vecs[v].nw - 1) * 4));
            check({vecs[v].name, "/data_hold"}, bus.write_data, (vecs[v].nw == 1) ? vecs[v].d0 : vecs[v].d1);
         end
      end

      // Reset acts asynchronously: outputs clear before the next clock edge
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check("async_reset/outputs", {28'd0, bus.write_enable, cpu_reset_n, load_done, load_error}, 32'd0);
      check("async_reset/address", bus.address, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Short low glitch on an idle line is not a start bit; an empty image still loads afterwards
      do_reset();
      io_rx = 1'b0;
      repeat (3) @(negedge clk);
      io_rx = 1'b1;
      repeat (50) @(negedge clk);
      check("glitch/load_error", {31'd0, load_error}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
      send_img(96'h00_00_00_00_00_00_00_00_00_00_00_00, 3, -1);
`else
      send_img(96'h00_00_00_00_00_00_00_00_00_00_00_00, 2, -1);
`endif
      repeat (30) @(negedge clk);
      check("glitch/load_done", {31'd0, load_done}, 32'd1);
      check("glitch/load_error_after", {31'd0, load_error}, 32'd0);
      check_writes("glitch", 0, 32'h0, 32'h0);

      // Abort mid-load, then a fresh one-word image writes only the new data
      do_reset();
      send_img(96'h01_00_AA_BB_00_00_00_00_00_00_00_00, 4, -1);
      io_rx = 1'b0;
      repeat (15) @(negedge clk);
      #2 reset_n = 1'b0;
      io_rx = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("abort/n_writes", 32'(wr_addr.size()), 32'd0);
      wr_addr.delete();
      wr_data.delete();
      long_strobes = 0;
`ifdef LOADER_CHECKSUM_EN
      send_img(96'h01_00_11_22_33_44_44_00_00_00_00_00, 7, -1);
`else
      send_img(96'h01_00_11_22_33_44_00_00_00_00_00_00, 6, -1);
`endif
      repeat (30) @(negedge clk);
      check_writes("reload", 1, 32'h44332211, 32'h0);
      check("reload/load_done", {31'd0, load_done}, 32'd1);
      check("reload/cpu_reset_n", {31'd0, cpu_reset_n}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
